// File: rtl/sm83_pkg.sv
// Shared SM83 bus types plus the DIV/TIMA/TMA/TAC timer definitions.
// Address offsets, timer FSM states, TAC layout and tick-bit select.
package sm83_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    localparam logic [1:0] TIMER_DIV_OFS  = 2'd0;
    localparam logic [1:0] TIMER_TIMA_OFS = 2'd1;
    localparam logic [1:0] TIMER_TMA_OFS  = 2'd2;
    localparam logic [1:0] TIMER_TAC_OFS  = 2'd3;

    typedef enum logic [1:0] {
        TS_RUN,
        TS_OVF,
        TS_RELOAD
    } timer_state_t;

    typedef struct packed {
        logic       en;
        logic [1:0] clk_sel;
    } tac_t;

    // Level of the TAC-selected counter bit, gated by the enable.
    function automatic logic tick_level(logic [15:0] cnt, tac_t tac);
        logic b;
        unique case (tac.clk_sel)
            2'b00: b = cnt[9];
            2'b01: b = cnt[3];
            2'b10: b = cnt[5];
            2'b11: b = cnt[7];
        endcase
        return tac.en & b;
    endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// Falling-edge detector on the TAC-selected system counter bit.
// Inputs are next-state counter/TAC, so resync can load the post-write level.
module timer_tick_gen
    import sm83_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sys_cnt_i,
    input  logic [2:0]  tac_i,
    input  logic        resync_i,
    output logic        tick_o
);

    logic lvl_d;
    logic lvl_q;
    logic hist_q;
    logic tick_q;

    assign lvl_d  = tick_level(sys_cnt_i, tac_t'(tac_i));
    assign tick_o = tick_q;

    // Track current level and previous level; register the 1->0 transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q  <= 1'b0;
            hist_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            lvl_q  <= lvl_d;
            hist_q <= resync_i ? lvl_d : lvl_q;
            tick_q <= hist_q & ~lvl_q;
        end
    end

endmodule

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer bus responder with delayed TMA reload and IRQ.
// GB_TIMER_DIV_GLITCH_EN: DIV/TAC writes may cause a spurious TIMA tick.
module gb_timer
    import sm83_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] r_addr,
    output logic [7:0]  r_data,
    output logic        r_hit,
    input  logic [15:0] w_addr,
    input  logic [7:0]  w_data,
    input  logic        w_wen,
    output logic        irq_timer
);

    logic [15:0]  r_ofs;
    logic [15:0]  w_ofs;
    logic         w_hit;
    logic         div_we;
    logic         tima_we;
    logic         tma_we;
    logic         tac_we;
    logic         resync;
    logic         tick;

    logic [15:0]  sys_cnt_d;
    logic [15:0]  sys_cnt_q;
    logic [2:0]   tac_d;
    logic [2:0]   tac_q;
    logic [7:0]   tima_q;
    logic [7:0]   tma_q;
    logic         irq_q;
    timer_state_t state_q;

    assign r_ofs   = r_addr - BASE_ADDR;
    assign w_ofs   = w_addr - BASE_ADDR;
    assign r_hit   = r_ofs < 16'd4;
    assign w_hit   = w_wen & (w_ofs < 16'd4);
    assign div_we  = w_hit & (w_ofs[1:0] == TIMER_DIV_OFS);
    assign tima_we = w_hit & (w_ofs[1:0] == TIMER_TIMA_OFS);
    assign tma_we  = w_hit & (w_ofs[1:0] == TIMER_TMA_OFS);
    assign tac_we  = w_hit & (w_ofs[1:0] == TIMER_TAC_OFS);

    assign sys_cnt_d = div_we ? 16'h0000 : sys_cnt_q + 16'd1;
    assign tac_d     = tac_we ? w_data[2:0] : tac_q;
    assign irq_timer = irq_q;

`ifdef GB_TIMER_DIV_GLITCH_EN
    assign resync = 1'b0;
`else
    assign resync = div_we | tac_we;
`endif

    timer_tick_gen u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .sys_cnt_i (sys_cnt_d),
        .tac_i     (tac_d),
        .resync_i  (resync),
        .tick_o    (tick)
    );

    // Free-running system counter and TAC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_cnt_q <= 16'h0000;
            tac_q     <= 3'b000;
        end else begin
            sys_cnt_q <= sys_cnt_d;
            tac_q     <= tac_d;
        end
    end

    // Combinational register read-back; misses float high.
    always_comb begin
        r_data = 8'hFF;
        if (r_hit) begin
            unique case (r_ofs[1:0])
                TIMER_DIV_OFS:  r_data = sys_cnt_q[15:8];
                TIMER_TIMA_OFS: r_data = tima_q;
                TIMER_TMA_OFS:  r_data = tma_q;
                TIMER_TAC_OFS:  r_data = {5'b11111, tac_q};
            endcase
        end
    end

    // TIMA counting, overflow, delayed reload and IRQ pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TS_RUN;
            tima_q  <= 8'h00;
            tma_q   <= 8'h00;
            irq_q   <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (tma_we) tma_q <= w_data;
            case (state_q)
                TS_RUN: begin
                    if (tima_we) begin
                        tima_q <= w_data;
                    end else if (tick) begin
                        if (tima_q == 8'hFF) begin
                            tima_q  <= 8'h00;
                            state_q <= TS_OVF;
                        end else begin
                            tima_q <= tima_q + 8'd1;
                        end
                    end
                end
                TS_OVF: begin
                    if (tima_we) begin
                        tima_q  <= w_data;
                        state_q <= TS_RUN;
                    end else begin
                        tima_q  <= tma_we ? w_data : tma_q;
                        irq_q   <= 1'b1;
                        state_q <= TS_RELOAD;
                    end
                end
                TS_RELOAD: begin
                    if (tma_we) tima_q <= w_data;
                    state_q <= TS_RUN;
                end
                default: state_q <= TS_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_timer.sv
// Directed self-checking bench for gb_timer.
// Expected values are hand-derived; GB_TIMER_DIV_GLITCH_EN selects glitch result.
module tb_gb_timer;
    import sm83_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic        r_hit;
    logic [15:0] w_addr;
    logic [7:0]  w_data;
    logic        w_wen;
    logic        irq_timer;

    int checks   = 0;
    int failures = 0;

    localparam logic [15:0] A_DIV  = 16'hFF04;
    localparam logic [15:0] A_TIMA = 16'hFF05;
    localparam logic [15:0] A_TMA  = 16'hFF06;
    localparam logic [15:0] A_TAC  = 16'hFF07;

    gb_timer #(.BASE_ADDR(16'hFF04)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .r_hit     (r_hit),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .w_wen     (w_wen),
        .irq_timer (irq_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [15:0] a,
                          input logic [7:0] exp);
        r_addr = a;
        #1;
        chk(tag, r_data, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {7'b0, irq_timer}, {7'b0, exp});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        w_addr = a;
        w_data = d;
        w_wen  = 1'b1;
        @(posedge clk);
        #1;
        w_wen  = 1'b0;
    endtask

    // Leaves the timer in the TS_OVF cycle with TMA = A0.
    task automatic setup_ovf();
        wr(A_TAC, 8'h00);
        step(3);
        wr(A_DIV, 8'h00);
        wr(A_TMA, 8'hA0);
        wr(A_TIMA, 8'hFF);
        wr(A_TAC, 8'h05);
        step(14);
        chk_rd("pre_ovf_tima", A_TIMA, 8'hFF);
        step(1);
        chk_rd("ovf_tima_zero", A_TIMA, 8'h00);
        chk_irq("ovf_irq_low", 1'b0);
    endtask

    // TIMA must step 0->1 exactly 'period' edges after the TAC write.
    task automatic period_chk(input logic [7:0] tac, input int period);
        wr(A_TAC, 8'h00);
        step(3);
        wr(A_DIV, 8'h00);
        wr(A_TIMA, 8'h00);
        wr(A_TAC, tac);
        step(period - 1);
        chk_rd($sformatf("period_%0d_before", period), A_TIMA, 8'h00);
        step(1);
        chk_rd($sformatf("period_%0d_at", period), A_TIMA, 8'h01);
    endtask

    initial begin
        rst_n  = 1'b0;
        r_addr = 16'h0000;
        w_addr = 16'h0000;
        w_data = 8'h00;
        w_wen  = 1'b0;

        // Reset read-back
        #3;
        chk_rd("rst_div", A_DIV, 8'h00);
        chk_rd("rst_tima", A_TIMA, 8'h00);
        chk_rd("rst_tma", A_TMA, 8'h00);
        chk_rd("rst_tac", A_TAC, 8'hF8);
        chk_irq("rst_irq", 1'b0);
        chk_rd("miss_low", 16'hFF03, 8'hFF);
        chk("miss_low_hit", {7'b0, r_hit}, 8'h00);
        chk_rd("miss_high", 16'hFF08, 8'hFF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fast tick rate: increments at TAC write + 17, 33, 49
        wr(A_DIV, 8'h00);
        wr(A_TAC, 8'h05);
        chk_rd("tac_rd", A_TAC, 8'hFD);
        step(48);
        chk_rd("fast_tima_48", A_TIMA, 8'h02);
        step(1);
        chk_rd("fast_tima_49", A_TIMA, 8'h03);
        chk_rd("fast_div", A_DIV, 8'h00);

        // DIV tracks sys_cnt[15:8]
        wr(A_TAC, 8'h00);
        wr(A_DIV, 8'h00);
        step(255);
        chk_rd("div_255", A_DIV, 8'h00);
        step(1);
        chk_rd("div_256", A_DIV, 8'h01);

        // Overflow and reload
        setup_ovf();
        step(1);
        chk_rd("reload_tima", A_TIMA, 8'hA0);
        chk_irq("reload_irq", 1'b1);
        step(1);
        chk_rd("after_reload_tima", A_TIMA, 8'hA0);
        chk_irq("after_reload_irq", 1'b0);

        // Cancel in overflow
        setup_ovf();
        wr(A_TIMA, 8'h42);
        chk_rd("cancel_tima", A_TIMA, 8'h42);
        chk_irq("cancel_irq", 1'b0);
        step(1);
        chk_rd("cancel_tima_hold", A_TIMA, 8'h42);
        chk_irq("cancel_irq_hold", 1'b0);
        chk_rd("cancel_tma", A_TMA, 8'hA0);

        // TMA write in overflow feeds the reload
        setup_ovf();
        wr(A_TMA, 8'h77);
        chk_rd("ovf_tma_tima", A_TIMA, 8'h77);
        chk_irq("ovf_tma_irq", 1'b1);

        // TMA write in reload
        setup_ovf();
        step(1);
        wr(A_TMA, 8'h5C);
        chk_rd("rel_tma_tima", A_TIMA, 8'h5C);
        chk_rd("rel_tma_tma", A_TMA, 8'h5C);
        chk_irq("rel_tma_irq", 1'b0);

        // TIMA write in reload is ignored
        setup_ovf();
        step(1);
        wr(A_TIMA, 8'h11);
        chk_rd("rel_tima_ignored", A_TIMA, 8'hA0);

        // Reset mid-overflow aborts reload and IRQ
        setup_ovf();
        rst_n = 1'b0;
        #1;
        chk_irq("rst_ovf_irq", 1'b0);
        chk_rd("rst_ovf_tima", A_TIMA, 8'h00);
        step(1);
        rst_n = 1'b1;
        step(2);
        chk_irq("rst_ovf_irq_after", 1'b0);
        chk_rd("rst_ovf_tima_after", A_TIMA, 8'h00);

        // Counter periods for each clock select
        period_chk(8'h05, 16);
        period_chk(8'h06, 64);
        period_chk(8'h07, 256);
        period_chk(8'h04, 1024);

        // DIV write glitch with sys_cnt[3] = 1
        wr(A_TAC, 8'h00);
        step(3);
        wr(A_DIV, 8'h00);
        wr(A_TIMA, 8'h10);
        wr(A_TAC, 8'h05);
        step(8);
        wr(A_DIV, 8'h00);
        chk_rd("glitch_div", A_DIV, 8'h00);
        chk_rd("glitch_tima_now", A_TIMA, 8'h10);
        step(2);
`ifdef GB_TIMER_DIV_GLITCH_EN
        chk_rd("glitch_tima", A_TIMA, 8'h11);
`else
        chk_rd("glitch_tima", A_TIMA, 8'h10);
`endif
        chk_rd("glitch_div_after", A_DIV, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
